// File: rtl/pll_reconfig_pkg.sv
// Shared constants and types for the PLL reconfiguration sequencer.
// Register map, FSM states and C-word field layout.
package pll_reconfig_pkg;

   localparam int CW      = 18;
   localparam int IDX_LSB = 18;
   localparam int IDX_W   = 5;
   localparam int TW      = 17;

   localparam logic [5:0] ADDR_MODE   = 6'd0;
   localparam logic [5:0] ADDR_STATUS = 6'd1;
   localparam logic [5:0] ADDR_START  = 6'd2;
   localparam logic [5:0] ADDR_N      = 6'd3;
   localparam logic [5:0] ADDR_M      = 6'd4;
   localparam logic [5:0] ADDR_C      = 6'd5;

   typedef enum logic [3:0] {
      S_IDLE,
      S_MODE,
      S_N,
      S_M,
      S_C,
      S_START,
      S_STATUS,
      S_LOCK,
      S_DONE
   } state_e;

   function automatic logic [31:0] c_word(
      input logic [IDX_W-1:0] idx,
      input logic [CW-1:0]    c
   );
      return {{(32-IDX_LSB-IDX_W){1'b0}}, idx, c};
   endfunction

endpackage

// File: rtl/pll_reconfig_if.sv
// Avalon-MM management port between the sequencer and the PLL
// reconfiguration IP.
interface pll_reconfig_if;

   logic [5:0]  mgmt_address;
   logic        mgmt_write;
   logic        mgmt_read;
   logic [31:0] mgmt_writedata;
   logic [31:0] mgmt_readdata;
   logic        mgmt_waitrequest;

   modport master (
      output mgmt_address,
      output mgmt_write,
      output mgmt_read,
      output mgmt_writedata,
      input  mgmt_readdata,
      input  mgmt_waitrequest
   );

   modport slave (
      input  mgmt_address,
      input  mgmt_write,
      input  mgmt_read,
      input  mgmt_writedata,
      output mgmt_readdata,
      output mgmt_waitrequest
   );

endinterface

// File: rtl/pll_lock_mon.sv
// Lock synchroniser, lock-stability counter and the saturating
// timeout counter shared by the STATUS poll and LOCK wait.
module pll_lock_mon
   import pll_reconfig_pkg::*;
#(
   parameter int LOCK_STABLE = 4,
   parameter int TIMEOUT     = 65535
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pll_locked,
   input  logic clear_tmo,
   input  logic clear_stab,
   input  logic enable,
   output logic stable,
   output logic timeout
);

   localparam int SW = $clog2(LOCK_STABLE + 1);

   logic [1:0]    sync_q;
   logic [SW-1:0] stab_q;
   logic [TW-1:0] tmo_q;
   logic          lock_s;

   assign lock_s = sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         stab_q <= '0;
         tmo_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], pll_locked};
         if (clear_stab || !lock_s)
            stab_q <= '0;
         else if (enable && stab_q != SW'(LOCK_STABLE))
            stab_q <= stab_q + 1'b1;
         if (clear_tmo)
            tmo_q <= '0;
         else if (enable && tmo_q != '1)
            tmo_q <= tmo_q + 1'b1;
      end
   end

   // Both flags fire in the cycle the count is reached, so the FSM
   // leaves on that same edge.
   assign stable  = enable && lock_s &&
                    (stab_q == SW'(LOCK_STABLE - 1));
   assign timeout = enable && (tmo_q >= TW'(TIMEOUT - 1));

endmodule

// File: rtl/pll_reconfig_seq.sv
// Runtime PLL reconfiguration sequencer: writes MODE/N/M/C, starts
// the reconfiguration, polls STATUS and waits for a stable lock.
module pll_reconfig_seq
   import pll_reconfig_pkg::*;
#(
   parameter int NUM_CLK     = 3,
   parameter int LOCK_STABLE = 4,
   parameter int TIMEOUT     = 65535
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_start,
   input  logic [CW-1:0]         cfg_n,
   input  logic [CW-1:0]         cfg_m,
   input  logic [CW*NUM_CLK-1:0] cfg_c,
   input  logic [NUM_CLK-1:0]    cfg_c_en,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   pll_reconfig_if.master        mgmt,
   input  logic                  pll_locked
);

   state_e st, nxt;

   logic [CW-1:0]         n_q, m_q;
   logic [CW*NUM_CLK-1:0] c_q;
   logic [NUM_CLK-1:0]    pend_q, pend_rest;
   logic                  err_q;

   logic [IDX_W-1:0] c_idx;
   logic [CW-1:0]    c_sel;
   logic             xfer_ok, accept, set_err;
   logic             stable, timeout;
   logic [5:0]       addr;
   logic [31:0]      wdata;
   logic             wr, rd;
   logic             unused_rdata;

   assign xfer_ok      = !mgmt.mgmt_waitrequest;
   assign unused_rdata = ^mgmt.mgmt_readdata[31:1];
   assign pend_rest    = pend_q & (pend_q - NUM_CLK'(1));

   // Lowest pending counter is the next one written.
   always_comb begin
      c_idx = '0;
      c_sel = '0;
      for (int i = NUM_CLK - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            c_idx = IDX_W'(i);
            c_sel = c_q[i*CW +: CW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= S_IDLE;
      else        st <= nxt;
   end

   always_comb begin
      nxt     = st;
      addr    = '0;
      wdata   = '0;
      wr      = 1'b0;
      rd      = 1'b0;
      accept  = 1'b0;
      set_err = 1'b0;
      unique case (st)
         S_IDLE: begin
            if (cfg_start) begin
               accept = 1'b1;
               nxt    = S_MODE;
            end
         end
         S_MODE: begin
            wr    = 1'b1;
            addr  = ADDR_MODE;
            wdata = 32'd1;
            if (xfer_ok) nxt = S_N;
         end
         S_N: begin
            wr    = 1'b1;
            addr  = ADDR_N;
            wdata = {14'b0, n_q};
            if (xfer_ok) nxt = S_M;
         end
         S_M: begin
            wr    = 1'b1;
            addr  = ADDR_M;
            wdata = {14'b0, m_q};
            if (xfer_ok) nxt = (|pend_q) ? S_C : S_START;
         end
         S_C: begin
            wr    = 1'b1;
            addr  = ADDR_C;
            wdata = c_word(c_idx, c_sel);
            if (xfer_ok && pend_rest == '0) nxt = S_START;
         end
         S_START: begin
            wr   = 1'b1;
            addr = ADDR_START;
            if (xfer_ok) nxt = S_STATUS;
         end
         S_STATUS: begin
            if (timeout) begin
               set_err = 1'b1;
               nxt     = S_DONE;
            end else begin
               rd   = 1'b1;
               addr = ADDR_STATUS;
               if (xfer_ok && mgmt.mgmt_readdata[0]) nxt = S_LOCK;
            end
         end
         S_LOCK: begin
            if (timeout) begin
               set_err = 1'b1;
               nxt     = S_DONE;
            end else if (stable) begin
               nxt = S_DONE;
            end
         end
         S_DONE:  nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q    <= '0;
         m_q    <= '0;
         c_q    <= '0;
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (accept) begin
            n_q    <= cfg_n;
            m_q    <= cfg_m;
            c_q    <= cfg_c;
            pend_q <= cfg_c_en;
            err_q  <= 1'b0;
         end else if (set_err) begin
            err_q <= 1'b1;
         end
         if (st == S_C && xfer_ok) pend_q <= pend_rest;
      end
   end

   pll_lock_mon #(
      .LOCK_STABLE (LOCK_STABLE),
      .TIMEOUT     (TIMEOUT)
   ) u_lock_mon (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .clear_tmo  (st == S_START),
      .clear_stab (st == S_STATUS),
      .enable     (st == S_STATUS || st == S_LOCK),
      .stable     (stable),
      .timeout    (timeout)
   );

   assign mgmt.mgmt_address   = addr;
   assign mgmt.mgmt_writedata = wdata;
   assign mgmt.mgmt_write     = wr;
   assign mgmt.mgmt_read      = rd;

   assign busy  = (st != S_IDLE) && (st != S_DONE);
   assign done  = (st == S_DONE);
   assign error = err_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench for pll_reconfig_seq: expected Avalon transfers
// and done pulses are queued per request and checked by a monitor.
module tb_pll_reconfig_seq;

   localparam int NC = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_start;
   logic [17:0]   cfg_n, cfg_m;
   logic [18*NC-1:0] cfg_c;
   logic [NC-1:0] cfg_c_en;
   logic          busy, done, error;
   logic          pll_locked;

   int cyc = 0;
   int t0  = 0;
   int vecs = 0;
   int fails = 0;
   int stall_left = 0;
   logic [5:0] stall_addr = '0;
   int status_zero = 0;

   typedef struct {
      int          kind;
      logic [5:0]  addr;
      logic [31:0] data;
      int          rel;
      logic        err;
   } exp_t;

   exp_t q[$];

   pll_reconfig_if m ();

   assign m.mgmt_waitrequest = m.mgmt_write &&
                               (m.mgmt_address == stall_addr) &&
                               (stall_left != 0);
   assign m.mgmt_readdata = {31'b0, status_zero == 0};

   pll_reconfig_seq #(
      .NUM_CLK     (NC),
      .LOCK_STABLE (4),
      .TIMEOUT     (100)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_start  (cfg_start),
      .cfg_n      (cfg_n),
      .cfg_m      (cfg_m),
      .cfg_c      (cfg_c),
      .cfg_c_en   (cfg_c_en),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .mgmt       (m),
      .pll_locked (pll_locked)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (m.mgmt_waitrequest) stall_left <= stall_left - 1;
      if (m.mgmt_read && !m.mgmt_waitrequest && status_zero > 0)
         status_zero <= status_zero - 1;
   end

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] cw(input int i,
                                      input logic [17:0] c);
      logic [4:0] ix;
      ix = 5'(i);
      return {9'b0, ix, c};
   endfunction

   task automatic pw(input logic [5:0] a, input logic [31:0] d,
                     input int r);
      exp_t e;
      e.kind = 0; e.addr = a; e.data = d; e.rel = r; e.err = 0;
      q.push_back(e);
   endtask

   task automatic pr(input int r);
      exp_t e;
      e.kind = 1; e.addr = 6'd1; e.data = '0; e.rel = r; e.err = 0;
      q.push_back(e);
   endtask

   task automatic pd(input int r, input logic er);
      exp_t e;
      e.kind = 2; e.addr = '0; e.data = '0; e.rel = r; e.err = er;
      q.push_back(e);
   endtask

   // Expected write sequence; mstall = extra cycles held on the M write.
   task automatic push_cfg(input logic [17:0] n, input logic [17:0] mm,
                           input logic [18*NC-1:0] c,
                           input logic [NC-1:0] en, input int mstall);
      int r;
      r = 1;
      pw(6'd0, 32'd1, r);
      r++;
      pw(6'd3, {14'b0, n}, r);
      r = r + 1 + mstall;
      pw(6'd4, {14'b0, mm}, r);
      for (int i = 0; i < NC; i++) begin
         if (en[i]) begin
            r++;
            pw(6'd5, cw(i, c[i*18 +: 18]), r);
         end
      end
      r++;
      pw(6'd2, 32'd0, r);
   endtask

   task automatic start(input logic [17:0] n, input logic [17:0] mm,
                        input logic [18*NC-1:0] c,
                        input logic [NC-1:0] en);
      @(posedge clk);
      #1;
      cfg_n = n; cfg_m = mm; cfg_c = c; cfg_c_en = en;
      cfg_start = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      cfg_n = ~n; cfg_m = ~mm; cfg_c = ~c; cfg_c_en = ~en;
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while (q.size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      chk("drain_pending", q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         if (m.mgmt_write || m.mgmt_read) begin
            chk("busy_strobe", busy, 1);
            if (q.size() == 0) begin
               vecs++;
               fails++;
               $display("FAIL unexpected_xfer: addr %0h data %0h, none expected",
                        m.mgmt_address, m.mgmt_writedata);
            end else begin
               e = q[0];
               chk("xfer_kind", m.mgmt_write ? 0 : 1, e.kind);
               chk("xfer_addr", m.mgmt_address, e.addr);
               if (m.mgmt_write)
                  chk("xfer_data", m.mgmt_writedata, e.data);
               if (!m.mgmt_waitrequest) begin
                  chk("xfer_cycle", cyc - t0, e.rel);
                  void'(q.pop_front());
               end
            end
         end
         if (done) begin
            if (q.size() == 0) begin
               vecs++;
               fails++;
               $display("FAIL unexpected_done: at cycle %0d, none expected",
                        cyc - t0);
            end else begin
               e = q.pop_front();
               chk("done_kind", 2, e.kind);
               chk("done_cycle", cyc - t0, e.rel);
               chk("done_error", error, e.err);
               chk("done_busy", busy, 0);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

   localparam logic [18*NC-1:0] C3 = {18'h00C03, 18'h00B02, 18'h00A01};

   initial begin
      int rel;
      rst_n = 1'b1;
      cfg_start = 0; cfg_n = 0; cfg_m = 0; cfg_c = 0; cfg_c_en = 0;
      pll_locked = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_write", m.mgmt_write, 0);
      chk("rst_read", m.mgmt_read, 0);
      chk("rst_addr", m.mgmt_address, 0);
      chk("rst_wdata", m.mgmt_writedata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      pll_locked = 1'b1;
      repeat (4) @(posedge clk);

      // Zero-wait, all counters, lock already stable
      push_cfg(18'h00202, 18'h00404, C3, 3'b111, 0);
      pr(8);
      pd(13, 1'b0);
      start(18'h00202, 18'h00404, C3, 3'b111);
      drain(60);

      // Reset while the C1 write is on the bus
      pw(6'd0, 32'd1, 1);
      pw(6'd3, 32'h00303, 2);
      pw(6'd4, 32'h00505, 3);
      pw(6'd5, cw(0, 18'h00A01), 4);
      start(18'h00303, 18'h00505, C3, 3'b111);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_write", m.mgmt_write, 0);
      chk("mid_rst_addr", m.mgmt_address, 0);
      chk("mid_rst_wdata", m.mgmt_writedata, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_pending", q.size(), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // M write stalled 3 cycles, counters 0 and 2 only
      stall_addr <= 6'd4;
      stall_left <= 3;
      push_cfg(18'h01111, 18'h02222, C3, 3'b101, 3);
      pr(10);
      pd(15, 1'b0);
      start(18'h01111, 18'h02222, C3, 3'b101);
      drain(60);
      chk("stall_consumed", stall_left, 0);

      // Ten busy STATUS reads, lock glitch during LOCK
      status_zero <= 10;
      pll_locked = 1'b0;
      push_cfg(18'h00707, 18'h00909, C3, 3'b111, 0);
      for (int r = 8; r <= 18; r++) pr(r);
      pd(26, 1'b0);
      start(18'h00707, 18'h00909, C3, 3'b111);
      rel = cyc - t0;
      while (q.size() != 0 && rel < 60) begin
         @(posedge clk);
         #1;
         rel = cyc - t0;
         pll_locked = (rel == 17 || rel == 18 || rel >= 20);
      end
      drain(5);

      // Lock never arrives: timeout, ignored restarts
      pll_locked = 1'b0;
      push_cfg(18'h00123, 18'h00456, C3, 3'b111, 0);
      pr(8);
      pd(108, 1'b1);
      start(18'h00123, 18'h00456, C3, 3'b111);
      rel = cyc - t0;
      while (rel < 125) begin
         @(posedge clk);
         #1;
         rel = cyc - t0;
         cfg_start = (rel == 50 || rel == 108);
      end
      cfg_start = 1'b0;
      drain(5);
      chk("error_sticky", error, 1);
      chk("idle_busy", busy, 0);

      // Empty mask: START directly after M; error cleared on accept
      pll_locked = 1'b1;
      push_cfg(18'h00AAA, 18'h00BBB, C3, 3'b000, 0);
      pr(5);
      pd(10, 1'b0);
      start(18'h00AAA, 18'h00BBB, C3, 3'b000);
      chk("error_cleared", error, 0);
      drain(40);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
